// File: rtl/mig_query_ctrl.sv
// Host-side query controller for the page hot tracker: issues MIG/FLUSH queries
// and buffers the returned migration addresses in a first-word-fall-through FIFO.
module mig_query_ctrl #(
    parameter int unsigned ADDR_SIZE  = 28,
    parameter int unsigned CMD_WIDTH  = 4,
    parameter int unsigned MIG_TH     = 450,
    parameter int unsigned CNT_SIZE   = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 acc_valid,
    input  logic                 host_flush_req,
    output logic                 query_en,
    output logic [CMD_WIDTH-1:0] query_cmd,
    input  logic                 query_ready,
    input  logic                 mig_addr_en,
    input  logic [ADDR_SIZE-1:0] mig_addr,
    output logic                 mig_addr_ready,
    output logic                 host_addr_valid,
    output logic [ADDR_SIZE-1:0] host_addr,
    input  logic                 host_pop,
    output logic [FIFO_AW:0]     fifo_count,
    output logic [CNT_SIZE-1:0]  mig_query_cnt,
    output logic [CNT_SIZE-1:0]  flush_query_cnt
);

    localparam logic [CMD_WIDTH-1:0] CmdIdle  = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CmdMig   = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CmdFlush = CMD_WIDTH'(2);
    localparam logic [CNT_SIZE-1:0]  AccLast  = CNT_SIZE'(MIG_TH - 1);
    localparam logic [FIFO_AW:0]     FifoFull = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_t;

    state_t                state_q, state_d;
    logic                  query_en_d;
    logic [CMD_WIDTH-1:0]  query_cmd_d;
    logic [CNT_SIZE-1:0]   acc_cnt_q;
    logic                  mig_pend_q, flush_pend_q;
    logic                  take_mig, take_flush, mig_inc, flush_inc, acc_hit;

    assign acc_hit = acc_valid && (acc_cnt_q == AccLast);

    always_comb begin
        state_d     = state_q;
        query_en_d  = query_en;
        query_cmd_d = query_cmd;
        take_mig    = 1'b0;
        take_flush  = 1'b0;
        mig_inc     = 1'b0;
        flush_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_pend_q) begin
                    take_flush  = 1'b1;
                    state_d     = StIssue;
                    query_en_d  = 1'b1;
                    query_cmd_d = CmdFlush;
                end else if (mig_pend_q) begin
                    take_mig    = 1'b1;
                    state_d     = StIssue;
                    query_en_d  = 1'b1;
                    query_cmd_d = CmdMig;
                end
            end
            StIssue: begin
                if (query_en && query_ready) begin
                    flush_inc   = (query_cmd == CmdFlush);
                    mig_inc     = (query_cmd != CmdFlush);
                    state_d     = StRelease;
                    query_en_d  = 1'b0;
                    query_cmd_d = CmdIdle;
                end
            end
            StRelease: begin
                state_d     = StIdle;
                query_en_d  = 1'b0;
                query_cmd_d = CmdIdle;
            end
            default: begin
                state_d     = StIdle;
                query_en_d  = 1'b0;
                query_cmd_d = CmdIdle;
            end
        endcase
    end

    // A new request arriving in the same cycle the old one is consumed stays pending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= StIdle;
            query_en        <= 1'b0;
            query_cmd       <= CmdIdle;
            acc_cnt_q       <= '0;
            mig_pend_q      <= 1'b0;
            flush_pend_q    <= 1'b0;
            mig_query_cnt   <= '0;
            flush_query_cnt <= '0;
        end else begin
            state_q      <= state_d;
            query_en     <= query_en_d;
            query_cmd    <= query_cmd_d;
            mig_pend_q   <= acc_hit || (mig_pend_q && !take_mig);
            flush_pend_q <= host_flush_req || (flush_pend_q && !take_flush);
            if (acc_valid) begin
                acc_cnt_q <= acc_hit ? '0 : acc_cnt_q + 1'b1;
            end
            if (mig_inc) begin
                mig_query_cnt <= mig_query_cnt + 1'b1;
            end
            if (flush_inc) begin
                flush_query_cnt <= flush_query_cnt + 1'b1;
            end
        end
    end

    logic [ADDR_SIZE-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic                 push, pop;

    assign mig_addr_ready  = (fifo_count != FifoFull);
    assign host_addr_valid = (fifo_count != '0);
    assign host_addr       = host_addr_valid ? mem[rd_ptr_q] : '0;
    assign push            = mig_addr_en && mig_addr_ready;
    assign pop             = host_pop && host_addr_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= mig_addr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

endmodule
